// File: rtl/seqgen_pkg.sv
// Shared types and constants for the sequence generator: FSM state encoding,
// active-low 7-segment codes and the saturation limit of the sequence counter.
package seqgen_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD0 = 3'd1,
    ONE1  = 3'd2,
    ZEROS = 3'd3,
    ONE2  = 3'd4
  } state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0011000;
  localparam logic [6:0] SEG_ERR = 7'b0000111;

  localparam int MAX_COUNT = 99;

endpackage

// File: rtl/sequence_generator_seg7.sv
// seg7_decoder: combinational BCD digit to active-low 7-segment code.
// Values 10..15 show the error glyph.
module seg7_decoder
  import seqgen_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_ERR;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serial stimulus source emitting 0,1,{N zeros},1 per start
// request, with a saturating sequence counter shown on two 7-segment digits.
// Optional build macro SEQGEN_REPEAT_EN: a start seen in ONE2 chains the next
// sequence directly, without an idle cycle in between.
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int ZERO_W = 4,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              start,
  input  logic [ZERO_W-1:0] num_zeros,
  output logic              sig_out,
  output logic              sig_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count_sent,
  output logic [6:0]        disp0,
  output logic [6:0]        disp1
);

  state_t            state, state_next;
  logic [ZERO_W-1:0] zcnt, zcnt_next;
  logic              sig_next, active_next, done_next;
  logic [3:0]        ones, tens;
  logic [6:0]        seg_ones, seg_tens;

  // Next-state logic plus the values the registered outputs take in that state
  always_comb begin
    state_next = state;
    zcnt_next  = zcnt;
    case (state)
      IDLE: begin
        if (ena && start) begin
          state_next = LEAD0;
          zcnt_next  = num_zeros;
        end
      end
      LEAD0: state_next = ONE1;
      ONE1:  state_next = (zcnt != '0) ? ZEROS : ONE2;
      ZEROS: begin
        zcnt_next = zcnt - ZERO_W'(1);
        if (zcnt == ZERO_W'(1)) state_next = ONE2;
      end
      ONE2: begin
`ifdef SEQGEN_REPEAT_EN
        if (ena && start) begin
          state_next = LEAD0;
          zcnt_next  = num_zeros;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
    sig_next    = !((state_next == LEAD0) || (state_next == ZEROS));
    active_next = (state_next != IDLE);
    done_next   = (state_next == ONE2);
  end

  // State and registered outputs; ena low freezes state and marks the bit invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      zcnt      <= '0;
      sig_out   <= 1'b1;
      sig_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (ena) begin
      state     <= state_next;
      zcnt      <= zcnt_next;
      sig_out   <= sig_next;
      sig_valid <= active_next;
      busy      <= active_next;
      done      <= done_next;
    end else begin
      sig_valid <= 1'b0;
      done      <= 1'b0;
    end
  end

  // Saturating binary count with parallel BCD digits. done only rises on an
  // enabled cycle, so it is counted even if ena drops right after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_sent <= '0;
      ones       <= 4'd0;
      tens       <= 4'd0;
    end else if (done && (count_sent != CNT_W'(MAX_COUNT))) begin
      count_sent <= count_sent + CNT_W'(1);
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

  seg7_decoder u_seg_ones (.bcd(ones), .seg(seg_ones));
  seg7_decoder u_seg_tens (.bcd(tens), .seg(seg_tens));

  // Display registers, one cycle behind the digits, frozen while ena is low
  always_ff @(posedge clk) begin
    if (rst) begin
      disp0 <= SEG_0;
      disp1 <= SEG_0;
    end else if (ena) begin
      disp0 <= seg_ones;
      disp1 <= seg_tens;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: table of directed sequences plus
// hand-written reset, saturation and back-to-back cases.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst, ena, start;
  logic [3:0] num_zeros;
  logic       sig_out, sig_valid, busy, done;
  logic [6:0] count_sent, disp0, disp1;

  int checks = 0;
  int errors = 0;

  sequence_generator #(.ZERO_W(4), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .num_zeros(num_zeros),
    .sig_out(sig_out), .sig_valid(sig_valid), .busy(busy), .done(done),
    .count_sent(count_sent), .disp0(disp0), .disp1(disp1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nz;
    int          pause_at;
    bit          poke;
    int          len;
    logic [31:0] bits;
    int          busy_cyc;
    int          count;
    logic [6:0]  d0;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one start and follow the sequence until busy drops (bounded)
  task automatic run_seq(input int nz, input int pause_at, input bit poke,
                         output int nbits, output logic [31:0] bits,
                         output int busy_cyc, output int done_cnt,
                         output int done_at_bit, output bit finished);
    nbits = 0; bits = '0; busy_cyc = 0; done_cnt = 0; done_at_bit = -1;
    finished = 1'b0;
    num_zeros = 4'(nz);
    start = 1'b1;
    tick();
    start = 1'b0;
    num_zeros = ~4'(nz);
    for (int c = 0; c < 40; c++) begin
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cyc++;
      if (sig_valid) begin
        bits = {bits[30:0], sig_out};
        nbits++;
      end
      if (done) begin
        done_cnt++;
        done_at_bit = nbits;
      end
      ena = !(pause_at >= 0 && (c == pause_at || c == pause_at + 1));
      start = poke && (c == 2);
      tick();
    end
    ena = 1'b1;
    start = 1'b0;
  endtask

  int nbits, busy_cyc, done_cnt, done_at_bit, vcnt, dcnt;
  logic [31:0] bits;
  bit finished;

  initial begin
    vecs[0] = '{nz: 0,  pause_at: -1, poke: 1'b0, len: 3,  bits: 32'h3,     busy_cyc: 3,  count: 1, d0: 7'b1111001};
    vecs[1] = '{nz: 3,  pause_at: -1, poke: 1'b1, len: 6,  bits: 32'h11,    busy_cyc: 6,  count: 2, d0: 7'b0100100};
    vecs[2] = '{nz: 2,  pause_at: 2,  poke: 1'b0, len: 5,  bits: 32'h9,     busy_cyc: 7,  count: 3, d0: 7'b0110000};
    vecs[3] = '{nz: 1,  pause_at: -1, poke: 1'b0, len: 4,  bits: 32'h5,     busy_cyc: 4,  count: 4, d0: 7'b0011001};
    vecs[4] = '{nz: 15, pause_at: -1, poke: 1'b0, len: 18, bits: 32'h10001, busy_cyc: 18, count: 5, d0: 7'b0010010};

    rst = 1'b1; ena = 1'b0; start = 1'b0; num_zeros = 4'd0;
    tick(); tick();
    rst = 1'b0; ena = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_sig_out", sig_out, 1);
    chk("idle_sig_valid", sig_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_count", count_sent, 0);
    chk("idle_disp0", disp0, 7'b1000000);
    chk("idle_disp1", disp1, 7'b1000000);

    // Directed sequences from the table
    for (int v = 0; v < 5; v++) begin
      run_seq(vecs[v].nz, vecs[v].pause_at, vecs[v].poke,
              nbits, bits, busy_cyc, done_cnt, done_at_bit, finished);
      chk($sformatf("v%0d_finished", v), finished, 1);
      chk($sformatf("v%0d_nbits", v), nbits, vecs[v].len);
      chk($sformatf("v%0d_bits", v), bits, vecs[v].bits);
      chk($sformatf("v%0d_busy_cycles", v), busy_cyc, vecs[v].busy_cyc);
      chk($sformatf("v%0d_done_count", v), done_cnt, 1);
      chk($sformatf("v%0d_done_on_last_bit", v), done_at_bit, vecs[v].len);
      chk($sformatf("v%0d_count", v), count_sent, vecs[v].count);
      chk($sformatf("v%0d_gap_sig_out", v), sig_out, 1);
      chk($sformatf("v%0d_gap_valid", v), sig_valid, 0);
      tick();
      chk($sformatf("v%0d_disp0", v), disp0, vecs[v].d0);
      chk($sformatf("v%0d_disp1", v), disp1, 7'b1000000);
    end

    // Reset on the third bit of a sequence abandons it
    num_zeros = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rst_pre_third_bit", sig_out, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_sig_out", sig_out, 1);
    chk("rst_valid", sig_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count_sent, 0);
    chk("rst_disp0", disp0, 7'b1000000);
    run_seq(1, -1, 1'b0, nbits, bits, busy_cyc, done_cnt, done_at_bit, finished);
    chk("post_rst_nbits", nbits, 4);
    chk("post_rst_bits", bits, 32'h5);
    chk("post_rst_count", count_sent, 1);

    // Count up to saturation; tens carry checked on the way
    for (int i = 0; i < 99; i++) begin
      run_seq(1, -1, 1'b0, nbits, bits, busy_cyc, done_cnt, done_at_bit, finished);
      tick();
      if (!finished) chk("sat_seq_finished", finished, 1);
      if (i == 8) begin
        chk("ten_count", count_sent, 10);
        chk("ten_disp0", disp0, 7'b1000000);
        chk("ten_disp1", disp1, 7'b1111001);
      end
      if (i == 97) chk("reach_99", count_sent, 99);
    end
    chk("sat_count", count_sent, 99);
    chk("sat_disp0", disp0, 7'b0011000);
    chk("sat_disp1", disp1, 7'b0011000);

    // start held high: chaining behaviour
    num_zeros = 4'd1; start = 1'b1;
    tick();
    vcnt = 0; dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (sig_valid) vcnt++;
      if (done) dcnt++;
      tick();
    end
    start = 1'b0;
`ifdef SEQGEN_REPEAT_EN
    chk("held_start_valid_cycles", vcnt, 10);
`else
    chk("held_start_valid_cycles", vcnt, 8);
`endif
    chk("held_start_done_pulses", dcnt, 2);
    finished = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_finished", finished, 1);
    tick();
    chk("held_start_count_sat", count_sent, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Serial stimulus source for the 01[0*]1 detector. On a start request it emits one bit per enabled clock of the pattern 0,1,{N zeros},1, where N is a programmable zero count. It keeps a saturating count of completed sequences and shows it on two active-low 7-segment digits. It sits upstream of the detector on the same board and drives its sig_to_test input.

Parameters:
ZERO_W, 4, width of the num_zeros field; N ranges over 0..2^ZERO_W-1.
CNT_W, 7, width of the count_sent binary output; must hold 99.

Ports:
clk  input  1  main clock signal
rst  input  1  reset, synchronous, active-high
ena  input  1  enable; low freezes the generator
start  input  1  request one sequence; sampled only in IDLE with ena=1
num_zeros  input  ZERO_W  number of middle zeros N; captured on start acceptance
sig_out  output  1  serial pattern bit (feeds detector sig_to_test)
sig_valid  output  1  sig_out carries a pattern bit this cycle
busy  output  1  sequence in progress
done  output  1  one-cycle pulse coincident with the final 1 bit
count_sent  output  CNT_W  completed sequences, saturating at 99
disp0  output  7  ones digit, active-low segments
disp1  output  7  tens digit, active-low segments

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; sig_out=1, sig_valid=0, busy=0, done=0.
  - count_sent=0; disp0=disp1=7'b1000000.
  - Reset applies identically mid-sequence; the partial pattern is abandoned.
- States: IDLE, LEAD0, ONE1, ZEROS, ONE2. All outputs are registered.
  - IDLE: sig_out=1, sig_valid=0. If ena & start, capture num_zeros into zcnt and go to LEAD0.
  - LEAD0: sig_out=0, valid=1. Go to ONE1.
  - ONE1: sig_out=1, valid=1. Go to ZEROS if zcnt!=0, else ONE2.
  - ZEROS: sig_out=0, valid=1, zcnt decrements. Go to ONE2 when zcnt reaches 1 (exactly N zero cycles).
  - ONE2: sig_out=1, valid=1, done=1. Go to IDLE.
- Latency: start accepted at edge t gives the first bit (0) at t+1. A sequence is 3+N enabled cycles; busy is high on exactly those cycles.
- ena=0:
  - State, zcnt and counters hold; sig_valid=0, done=0; sig_out holds its last value.
  - Resuming continues the pattern without repeating or skipping bits.
- start outside IDLE is ignored (no queuing). Changes to num_zeros after capture are ignored.
- Counter: count_sent increments on the cycle after done; at 99 it stays at 99.
  - Ones and tens BCD digits are maintained in parallel, ones wrapping 9->0 with tens carry; no division.
- Display:
  - disp0/disp1 are registered decodes of the BCD digits, one cycle behind the counter, updated only when ena=1.
  - Codes 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
  - Any other value shows 0000111.

Optional Feature:
SEQGEN_REPEAT_EN.
- Defined: in ONE2, if start=1 and ena=1, capture num_zeros and go directly to LEAD0. Sequences are back-to-back with no IDLE gap; busy stays high and done pulses once per sequence.
- Undefined: ONE2 always returns to IDLE, so there is at least one idle cycle (sig_out=1, valid=0) between sequences.

Decomposition:
- Package seqgen_pkg holds:
  - the state enum typedef (logic [2:0]);
  - the 7-segment code constants for 0..9 and the blank/error code;
  - localparam MAX_COUNT=99.
- One sub-module, seg7_decoder: 4-bit BCD in, 7-bit active-low segments out, combinational. It is instantiated twice; the display registers stay in sequence_generator.

Test Plan:
- Reset, then idle 5 cycles -> sig_out=1, sig_valid=0, busy=0, count_sent=0, disp0=disp1=7'b1000000.
- start at t with num_zeros=0 -> sig_out 0,1,1 at t+1..t+3; done only at t+3; count_sent=1 at t+4; disp0=7'b1111001 at t+5.
- num_zeros=3 -> stream 0,1,0,0,0,1; busy high exactly 6 cycles; start pulsed mid-sequence is ignored.
- num_zeros=2 with ena=0 for 2 cycles during ZEROS -> valid low on those cycles; valid-qualified bits still 0,1,0,0,1; done once.
- rst asserted on the 3rd bit of a sequence -> next cycle IDLE, sig_out=1, count_sent=0; a fresh start then produces a complete pattern.
- 100 sequences with num_zeros=1 -> count_sent saturates at 99, disp0=disp1=7'b0011000. With SEQGEN_REPEAT_EN and start held high, the sequences run with no idle gap.
